// File: rtl/loader_pkg.sv
// Shared types and constants for the boot program loader.
package loader_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_HDR_ADDR = 3'd0,
        ST_HDR_LEN  = 3'd1,
        ST_DATA     = 3'd2,
        ST_CHECK    = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } state_t;

    // A length byte of zero requests a full 256-byte image.
    localparam int unsigned LEN_ZERO_MEANS_256 = 256;

    function automatic byte_t sum8(input byte_t acc, input byte_t b);
        return byte_t'(acc + b);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Streams a header+data image into memory and releases the CPU hold afterwards.
// Optional checksum byte and ERROR state enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 32'd0) ? $clog2(HOLD_CYCLES + 32'd1) : 1;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    byte_t               mem_wdata_r;
    logic [8:0]          len_r;
    logic [8:0]          cnt_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                mem_we_r;
    logic                cpu_hold_r;
    logic                done_r;
    logic                accept_s;
    logic                xfer_s;
    logic                last_data_s;
    logic                restart_s;
`ifdef LOADER_CHECKSUM_EN
    byte_t               sum_r;
    logic                error_r;
`endif

    // States in which a stream byte may be accepted.
    always_comb begin
        accept_s = 1'b0;
        case (state_r)
            ST_HDR_ADDR: accept_s = 1'b1;
            ST_HDR_LEN:  accept_s = 1'b1;
            ST_DATA:     accept_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK:    accept_s = 1'b1;
`endif
            default:     accept_s = 1'b0;
        endcase
    end

    assign in_ready    = accept_s & ~reset;
    assign xfer_s      = in_valid & in_ready;
    assign last_data_s = ((cnt_r + 9'd1) == len_r);
`ifdef LOADER_CHECKSUM_EN
    assign restart_s   = start & ((state_r == ST_DONE) | (state_r == ST_ERROR));
`else
    assign restart_s   = start & (state_r == ST_DONE);
`endif

    // Next-state decode; every advance is gated by an accepted byte.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_HDR_ADDR: begin
                if (xfer_s) state_next_s = ST_HDR_LEN;
                else        state_next_s = state_r;
            end
            ST_HDR_LEN: begin
                if (xfer_s) state_next_s = ST_DATA;
                else        state_next_s = state_r;
            end
            ST_DATA: begin
                if (xfer_s && last_data_s) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next_s = ST_CHECK;
`else
                    state_next_s = ST_DONE;
`endif
                end else begin
                    state_next_s = state_r;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer_s) state_next_s = (sum8(sum_r, in_data) == 8'd0) ? ST_DONE : ST_ERROR;
                else        state_next_s = state_r;
            end
            ST_ERROR: begin
                if (restart_s) state_next_s = ST_HDR_ADDR;
                else           state_next_s = state_r;
            end
`endif
            ST_DONE: begin
                if (restart_s) state_next_s = ST_HDR_ADDR;
                else           state_next_s = state_r;
            end
            default: state_next_s = ST_HDR_ADDR;
        endcase
    end

    // Loader state, header capture, memory write port and hold countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_HDR_ADDR;
            base_r      <= {ADDR_W{1'b0}};
            len_r       <= 9'd0;
            cnt_r       <= 9'd0;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'd0;
            cpu_hold_r  <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            mem_we_r <= 1'b0;
            case (state_r)
                ST_HDR_ADDR: begin
                    if (xfer_s) base_r <= ADDR_W'(in_data);
                end
                ST_HDR_LEN: begin
                    if (xfer_s) begin
                        len_r <= (in_data == 8'd0) ? 9'(LEN_ZERO_MEANS_256) : {1'b0, in_data};
                        cnt_r <= 9'd0;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= base_r + ADDR_W'(cnt_r);
                        mem_wdata_r <= in_data;
                        cnt_r       <= cnt_r + 9'd1;
                    end
                end
                ST_DONE: begin
                    if (restart_s) begin
                        done_r     <= 1'b0;
                        cpu_hold_r <= 1'b1;
                        hold_cnt_r <= {HOLD_W{1'b0}};
                        cnt_r      <= 9'd0;
                    end else if (hold_cnt_r != {HOLD_W{1'b0}}) begin
                        hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
                        if (hold_cnt_r == HOLD_W'(1)) cpu_hold_r <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Success: done rises now, hold released HOLD_CYCLES cycles later.
            if ((state_next_s == ST_DONE) && (state_r != ST_DONE)) begin
                done_r <= 1'b1;
                if (HOLD_CYCLES == 32'd0) cpu_hold_r <= 1'b0;
                else                      hold_cnt_r <= HOLD_W'(HOLD_CYCLES);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running byte sum and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r   <= 8'd0;
            error_r <= 1'b0;
        end else begin
            if (restart_s)   sum_r <= 8'd0;
            else if (xfer_s) sum_r <= sum8(sum_r, in_data);
            if (restart_s)   error_r <= 1'b0;
            else if ((state_next_s == ST_ERROR) && (state_r != ST_ERROR)) error_r <= 1'b1;
        end
    end

    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_hold  = cpu_hold_r;
    assign done      = done_r;

endmodule
